// File: rtl/record_fifo_pkg.sv
`default_nettype none
// ============================================================================
// record_fifo_pkg : pointer/count width helpers shared by the record FIFO
// Rev 1.0
// ============================================================================
package record_fifo_pkg;

    function automatic int idx_width(input int depth, input int rec_words);
        return $clog2(depth * rec_words);
    endfunction

    // One extra bit distinguishes full from empty.
    function automatic int ptr_width(input int depth, input int rec_words);
        return idx_width(depth, rec_words) + 1;
    endfunction

    function automatic int rec_log(input int rec_words);
        return $clog2(rec_words);
    endfunction

    function automatic int rec_idx_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int rec_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/record_fifo_mem.sv
`default_nettype none
// ============================================================================
// record_fifo_mem : word-wide write port, record-wide combinational read port
// Rev 1.0
// ============================================================================
module record_fifo_mem
    import record_fifo_pkg::*;
#(
    parameter int WordSize    = 8,
    parameter int RecordWords = 16,
    parameter int Depth       = 8
) (
    input  logic                                       clk,
    input  logic                                       wr_en_i,
    input  logic [idx_width(Depth, RecordWords)-1:0]   wr_addr_i,
    input  logic [WordSize-1:0]                        wr_data_i,
    input  logic [rec_idx_width(Depth)-1:0]            rd_rec_i,
    output logic [WordSize*RecordWords-1:0]            rd_data_o
);

    localparam int c_WORDS  = Depth * RecordWords;
    localparam int c_RW_LOG = rec_log(RecordWords);

    logic [WordSize-1:0] mem_q [c_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    for (genvar w = 0; w < RecordWords; w++) begin : g_rd
        localparam logic [c_RW_LOG-1:0] c_OFF = c_RW_LOG'(w);
        assign rd_data_o[w*WordSize +: WordSize] = mem_q[{rd_rec_i, c_OFF}];
    end

endmodule
`default_nettype wire

// File: rtl/record_fifo.sv
`default_nettype none
// ============================================================================
// record_fifo : assembles words into records and presents whole records only
// Rev 1.0
// ============================================================================
module record_fifo
    import record_fifo_pkg::*;
#(
    parameter int WordSize        = 8,
    parameter int RecordWords     = 16,
    parameter int Depth           = 8,
    parameter int AlmostFullWords = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      flush,
    input  logic                                      in_valid,
    input  logic [WordSize-1:0]                       data_in,
    output logic                                      in_ready,
    input  logic                                      drop_partial,
    output logic                                      out_valid,
    output logic [WordSize*RecordWords-1:0]           data_out,
    input  logic                                      out_ready,
    output logic [ptr_width(Depth, RecordWords)-1:0]  word_count,
    output logic [rec_count_width(Depth)-1:0]         record_count,
    output logic                                      almost_full,
    output logic                                      overflow
);

    localparam int c_IDX_W  = idx_width(Depth, RecordWords);
    localparam int c_PTR_W  = ptr_width(Depth, RecordWords);
    localparam int c_RW_LOG = rec_log(RecordWords);
    localparam int c_REC_W  = rec_idx_width(Depth);

    localparam logic [c_PTR_W-1:0] c_CAP      = c_PTR_W'(Depth * RecordWords);
    localparam logic [c_PTR_W-1:0] c_AF       = c_PTR_W'(AlmostFullWords);
    localparam logic [c_PTR_W-1:0] c_REC_STEP = c_PTR_W'(RecordWords);
    localparam logic [c_PTR_W-1:0] c_REC_MASK = ~(c_PTR_W'(RecordWords - 1));

    logic [c_PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic                            out_valid_q, out_valid_d;
    logic [WordSize*RecordWords-1:0] data_out_q, data_out_d;
    logic                            overflow_q, overflow_d;

    logic [c_PTR_W-1:0]              w_word_count;
    logic [c_PTR_W-1:0]              w_free;
    logic                            w_wr_en;
    logic                            w_load;
    logic [WordSize*RecordWords-1:0] w_rd_record;

    assign w_word_count = wr_ptr_q - rd_ptr_q;
    assign w_free       = c_CAP - w_word_count;
    assign in_ready     = (w_word_count < c_CAP);
    assign word_count   = w_word_count;
    assign record_count = w_word_count[c_PTR_W-1:c_RW_LOG];
    assign almost_full  = (w_free < c_AF);

    assign w_wr_en = in_valid && in_ready && !drop_partial && !flush;
    // Load decision uses pre-edge counts, so a word written this edge never
    // completes a record that is loaded on the same edge.
    assign w_load  = (record_count != '0) && (!out_valid_q || out_ready);

    record_fifo_mem #(
        .WordSize    (WordSize),
        .RecordWords (RecordWords),
        .Depth       (Depth)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (w_wr_en && rst_n),
        .wr_addr_i (wr_ptr_q[c_IDX_W-1:0]),
        .wr_data_i (data_in),
        .rd_rec_i  (rd_ptr_q[c_IDX_W-1 -: c_REC_W]),
        .rd_data_o (w_rd_record)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        overflow_d  = in_valid && !in_ready;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            if (drop_partial) begin
                wr_ptr_d = wr_ptr_q & c_REC_MASK;
            end else if (w_wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_load) begin
                rd_ptr_d    = rd_ptr_q + c_REC_STEP;
                out_valid_d = 1'b1;
                data_out_d  = w_rd_record;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_record_fifo.sv
`default_nettype none
// ============================================================================
// tb_record_fifo : directed vector table plus multi-cycle sequences
// Rev 1.0
// ============================================================================
module tb_record_fifo;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, drop_partial, out_ready;
    logic [7:0]  data_in;
    logic        in_ready, out_valid, almost_full, overflow;
    logic [31:0] data_out;
    logic [3:0]  word_count;
    logic [1:0]  record_count;

    int checks   = 0;
    int failures = 0;

    record_fifo #(
        .WordSize        (8),
        .RecordWords     (4),
        .Depth           (2),
        .AlmostFullWords (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .in_ready     (in_ready),
        .drop_partial (drop_partial),
        .out_valid    (out_valid),
        .data_out     (data_out),
        .out_ready    (out_ready),
        .word_count   (word_count),
        .record_count (record_count),
        .almost_full  (almost_full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [7:0]  din;
        logic        drop;
        logic        fl;
        logic        ordy;
        logic        eov;
        logic [31:0] edata;
        logic [3:0]  ewc;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [7:0] din, input logic drop,
                       input logic fl, input logic ordy, input logic eov,
                       input logic [31:0] edata, input logic [3:0] ewc, input logic eovf);
        vec_t v;
        v.iv = iv; v.din = din; v.drop = drop; v.fl = fl; v.ordy = ordy;
        v.eov = eov; v.edata = edata; v.ewc = ewc; v.eovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; data_in = 8'h00; drop_partial = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rec_of(input int base);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'((base + i) & 8'hFF);
        return r;
    endfunction

    // Write six words, then abort with reset or flush; afterwards a record
    // must only appear once four fresh words have been written.
    task automatic run_abort(input bit use_flush);
        string tag;
        tag = use_flush ? "flush" : "reset";
        idle_inputs();
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; data_in = 8'(8'h60 + i); step();
        end
        check({tag, "_pre_ov"}, out_valid, 1);
        check({tag, "_pre_data"}, data_out, 32'h63626160);
        data_in = 8'h66;
        if (use_flush) flush = 1'b1; else rst_n = 1'b0;
        step();
        flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
        check({tag, "_ov"}, out_valid, 0);
        check({tag, "_wc"}, word_count, 0);
        check({tag, "_rc"}, record_count, 0);
        check({tag, "_rdy"}, in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; data_in = 8'(8'h70 + i); step();
            check($sformatf("%s_refill%0d_ov", tag, i), out_valid, 0);
        end
        in_valid = 1'b0; step();
        check({tag, "_refill_ov"}, out_valid, 1);
        check({tag, "_refill_data"}, data_out, 32'h73727170);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check({tag, "_drain_ov"}, out_valid, 0);
    endtask

    initial begin
        int m_cnt, nxt, rec_rx, cyc;
        bit m_ov, acc, ld;

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_word_count", word_count, 0);
        check("rst_record_count", record_count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_almost_full", almost_full, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        //   iv din   drop fl  ordy eov edata          wc  ovf
        add(1, 8'h01, 0, 0, 0, 0, 32'h0,        4'd1, 0);
        add(1, 8'h02, 0, 0, 0, 0, 32'h0,        4'd2, 0);
        add(1, 8'h03, 0, 0, 0, 0, 32'h0,        4'd3, 0);
        add(1, 8'h04, 0, 0, 0, 0, 32'h0,        4'd4, 0);
        add(0, 8'h00, 0, 0, 0, 1, 32'h04030201, 4'd0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 32'h0,        4'd0, 0);
        add(1, 8'h10, 0, 0, 0, 0, 32'h0,        4'd1, 0);
        add(1, 8'h11, 0, 0, 0, 0, 32'h0,        4'd2, 0);
        add(1, 8'h12, 0, 0, 0, 0, 32'h0,        4'd3, 0);
        add(1, 8'h13, 0, 0, 0, 0, 32'h0,        4'd4, 0);
        add(1, 8'h14, 0, 0, 0, 1, 32'h13121110, 4'd1, 0);
        add(1, 8'h15, 0, 0, 0, 1, 32'h13121110, 4'd2, 0);
        add(1, 8'h16, 0, 0, 0, 1, 32'h13121110, 4'd3, 0);
        add(1, 8'h17, 0, 0, 0, 1, 32'h13121110, 4'd4, 0);
        add(1, 8'h18, 0, 0, 0, 1, 32'h13121110, 4'd5, 0);
        add(1, 8'h19, 0, 0, 0, 1, 32'h13121110, 4'd6, 0);
        add(1, 8'h1A, 0, 0, 0, 1, 32'h13121110, 4'd7, 0);
        add(1, 8'h1B, 0, 0, 0, 1, 32'h13121110, 4'd8, 0);
        add(1, 8'h1C, 0, 0, 0, 1, 32'h13121110, 4'd8, 1);
        add(0, 8'h00, 0, 0, 0, 1, 32'h13121110, 4'd8, 0);
        add(0, 8'h00, 0, 0, 1, 1, 32'h17161514, 4'd4, 0);
        add(0, 8'h00, 0, 0, 1, 1, 32'h1B1A1918, 4'd0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 32'h0,        4'd0, 0);
        add(1, 8'hA0, 0, 0, 0, 0, 32'h0,        4'd1, 0);
        add(1, 8'hA1, 0, 0, 0, 0, 32'h0,        4'd2, 0);
        add(1, 8'hA2, 1, 0, 0, 0, 32'h0,        4'd0, 0);
        add(1, 8'hB0, 0, 0, 0, 0, 32'h0,        4'd1, 0);
        add(1, 8'hB1, 0, 0, 0, 0, 32'h0,        4'd2, 0);
        add(1, 8'hB2, 0, 0, 0, 0, 32'h0,        4'd3, 0);
        add(1, 8'hB3, 0, 0, 0, 0, 32'h0,        4'd4, 0);
        add(0, 8'h00, 0, 0, 0, 1, 32'hB3B2B1B0, 4'd0, 0);
        add(0, 8'h00, 1, 0, 1, 0, 32'h0,        4'd0, 0);
        add(1, 8'hC0, 0, 0, 0, 0, 32'h0,        4'd1, 0);
        add(1, 8'hC1, 0, 0, 0, 0, 32'h0,        4'd2, 0);
        add(1, 8'hC2, 0, 0, 0, 0, 32'h0,        4'd3, 0);
        add(1, 8'hC3, 0, 0, 0, 0, 32'h0,        4'd4, 0);
        add(1, 8'hC4, 1, 0, 0, 1, 32'hC3C2C1C0, 4'd0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 32'h0,        4'd0, 0);
        add(1, 8'hD0, 0, 1, 0, 0, 32'h0,        4'd0, 0);

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv; data_in = vecs[i].din; drop_partial = vecs[i].drop;
            flush = vecs[i].fl; out_ready = vecs[i].ordy;
            step();
            check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].eov);
            check($sformatf("v%0d_word_count", i), word_count, vecs[i].ewc);
            check($sformatf("v%0d_record_count", i), record_count, vecs[i].ewc >> 2);
            check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].ewc < 4'd8);
            check($sformatf("v%0d_almost_full", i), almost_full, vecs[i].ewc >= 4'd7);
            check($sformatf("v%0d_overflow", i), overflow, vecs[i].eovf);
            if (vecs[i].eov) check($sformatf("v%0d_data_out", i), data_out, vecs[i].edata);
        end

        // Fill to full, then stream continuously with out_ready high.
        idle_inputs();
        flush = 1'b1; step(); flush = 1'b0;
        m_cnt = 0; m_ov = 0; nxt = 8'h40; rec_rx = 0; cyc = 0;
        while (rec_rx < 20 && cyc < 400) begin
            out_ready = (cyc >= 12);
            in_valid  = 1'b1;
            data_in   = 8'(nxt & 8'hFF);
            check($sformatf("stream%0d_out_valid", cyc), out_valid, m_ov);
            check($sformatf("stream%0d_in_ready", cyc), in_ready, m_cnt < 8);
            if (m_ov && out_ready) begin
                check($sformatf("stream_rec%0d", rec_rx), data_out, rec_of(8'h40 + 4 * rec_rx));
                rec_rx++;
            end
            acc = (m_cnt < 8);
            ld  = (m_cnt >= 4) && (!m_ov || out_ready);
            m_cnt = m_cnt + (acc ? 1 : 0) - (ld ? 4 : 0);
            if (acc) nxt++;
            m_ov = ld ? 1'b1 : ((m_ov && out_ready) ? 1'b0 : m_ov);
            step();
            cyc++;
        end
        check("stream_records", rec_rx, 20);
        idle_inputs();

        run_abort(1'b0);
        run_abort(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/record_fifo.md
RECORD_FIFO -- requirements
Module: record_fifo

Interface
REQ-001 Param WordSize, 8, bits per input word.
REQ-002 Param RecordWords, 16, words per record; power of 2, >=2.
REQ-003 Param Depth, 8, record capacity; power of 2, >=2.
REQ-004 Param AlmostFullWords, 4, almost_full asserts when free words < this value; range 1..Depth*RecordWords.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 flush  in  1  synchronous clear of all contents.
REQ-008 in_valid  in  1  data_in holds a word.
REQ-009 data_in  in  WordSize  input word.
REQ-010 in_ready  out  1  fifo accepts a word this cycle.
REQ-011 drop_partial  in  1  discard words of the incomplete record being assembled.
REQ-012 out_valid  out  1  data_out holds a complete record.
REQ-013 data_out  out  WordSize*RecordWords  record; first-written word in bits [WordSize-1:0].
REQ-014 out_ready  in  1  consumer takes the record.
REQ-015 word_count  out  clog2(Depth*RecordWords)+1  words stored, excluding the output register.
REQ-016 record_count  out  clog2(Depth)+1  complete records stored, excluding the output register.
REQ-017 almost_full  out  1  free words < AlmostFullWords.
REQ-018 overflow  out  1  one-cycle pulse, registered, when in_valid was high and in_ready low.

Function
REQ-019 Storage SHALL be Depth*RecordWords words, with write/read pointers one bit wider than the index, wrapping modulo 2*Depth*RecordWords.
REQ-020 in_ready SHALL equal (word_count < Depth*RecordWords), with no combinational dependence on out_ready or in_valid.
REQ-021 A word SHALL be written and wr_ptr incremented by 1 on every edge with in_valid && in_ready && !drop_partial && !flush.
REQ-022 record_count SHALL equal word_count >> clog2(RecordWords); partial records are never presented.
REQ-023 The output register SHALL load the oldest complete record, with rd_ptr += RecordWords, on an edge where record_count>0 and (!out_valid || out_ready).
REQ-024 out_valid SHALL fall on an edge where out_valid && out_ready and no record loads.
REQ-025 Latency: out_valid SHALL be high in the cycle after the edge that makes record_count go 0->1 with an empty output register.
REQ-026 out_valid, data_out SHALL be held stable while out_valid && !out_ready.
REQ-027 Simultaneous write and record load SHALL both take effect; the full check uses the pre-edge word_count.
REQ-028 drop_partial SHALL set wr_ptr to wr_ptr rounded down to a RecordWords boundary; a coincident in_valid word is discarded; with no partial record it is a no-op.
REQ-029 flush SHALL zero both pointers and clear out_valid on that edge, overriding write, load and drop.
REQ-030 Priority: rst_n low > flush > drop_partial > write; record load is independent of write.
REQ-031 almost_full, word_count, record_count SHALL be combinational from the pointers.

Reset
REQ-032 On an edge with rst_n low: pointers=0, out_valid=0, data_out=0, overflow=0; hence in_ready=1, word_count=0, record_count=0, almost_full=0.
REQ-033 Reset mid-record or mid-handshake SHALL discard all contents; no record is presented afterwards until RecordWords new words are written.
REQ-034 Storage array contents SHALL NOT be reset.

Structure
REQ-035 Package record_fifo_pkg SHALL hold the pointer/count width functions and derived-size localparam helpers.
REQ-036 Sub-module record_fifo_mem SHALL contain the storage array: one word write port and one combinational record-wide read port at a record-aligned address.
REQ-037 Control (pointers, output register, drop, flush) SHALL live in record_fifo.

Verification (WordSize=8, RecordWords=4, Depth=2, AlmostFullWords=2)
REQ-038 Write 0x01..0x04 with out_ready=0 -> out_valid high one cycle after the 4th write edge, data_out=0x04030201, record_count=0.
REQ-039 Write 12 words with out_ready=0 -> after 12 writes in_ready=0, word_count=8, almost_full=1; 13th in_valid -> overflow pulses once and no word is stored.
REQ-040 Write 0xA0,0xA1, assert drop_partial with in_valid and 0xA2 -> word_count=0; then write 0xB0..0xB3 -> data_out=0xB3B2B1B0.
REQ-041 Full with out_ready=1 and continuous writes -> one record per 4 cycles, in order, no gaps beyond in_valid gaps, wrap-around correct over 20 records.
REQ-042 Write 6 words, pulse rst_n low for one cycle mid-write -> out_valid=0, word_count=0, in_ready=1 the next cycle; flush gives identical results.
